// File: rtl/output_stream_writer.sv
// Output stream writer: buffers conv result pixels in a small skid FIFO
// and emits them as sign-extended 256-bit AXI-Stream beats per frame.
module output_stream_writer #(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  Reset,
    input  logic                  Start,
    input  logic [7:0]            IMAGE_SIZE,
    input  logic [DATA_WIDTH-1:0] pixel_in,
    input  logic                  pixel_valid,
    output logic                  pixel_ready,
    output logic [255:0]          m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,
    output logic                  Done_1row,
    output logic                  Done_frame,
    output logic                  Busy
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN,
        DONE
    } state_t;

    state_t state;
    state_t state_nx;

    logic [7:0]            n_size;
    logic [15:0]           total;
    logic [15:0]           in_count;
    logic [15:0]           out_count;
    logic [7:0]            col_count;
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW:0]           wr_ptr;
    logic [AW:0]           rd_ptr;
    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;
    logic                  start_ok;
    logic [DATA_WIDTH-1:0] head;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign start_ok    = (state == IDLE) && Start;
    assign pixel_ready = (state == STREAM) && !full && (in_count < total);
    assign push        = pixel_valid && pixel_ready;
    assign pop         = m_axis_tvalid && m_axis_tready;

    // Output is forced to zero while empty so reset and idle show no stale data.
    assign head          = mem[rd_ptr[AW-1:0]];
    assign m_axis_tvalid = !empty;
    assign m_axis_tdata  = empty ? '0 :
                           {{(256-DATA_WIDTH){head[DATA_WIDTH-1]}}, head};
    assign m_axis_tlast  = !empty && (out_count == total - 16'd1);

    assign Done_frame = (state == DONE);
    assign Busy       = (state != IDLE);

    // State register.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (Start) state_nx = (IMAGE_SIZE == 8'd0) ? DONE : STREAM;
            end
            STREAM: begin
                if (push && (in_count == total - 16'd1)) state_nx = DRAIN;
            end
            DRAIN: begin
                if (pop && m_axis_tlast) state_nx = DONE;
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Frame geometry, pixel/beat counters and the row-done pulse.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            n_size    <= '0;
            total     <= '0;
            in_count  <= '0;
            out_count <= '0;
            col_count <= '0;
            Done_1row <= 1'b0;
        end else begin
            Done_1row <= pop && (col_count == n_size - 8'd1);
            if (start_ok) begin
                n_size    <= IMAGE_SIZE;
                total     <= 16'(IMAGE_SIZE) * 16'(IMAGE_SIZE);
                in_count  <= '0;
                out_count <= '0;
                col_count <= '0;
            end else begin
                if (push) in_count <= in_count + 16'd1;
                if (pop) begin
                    out_count <= out_count + 16'd1;
                    col_count <= (col_count == n_size - 8'd1) ?
                                 8'd0 : col_count + 8'd1;
                end
            end
        end
    end

    // FIFO pointers; clearing them on reset drops any buffered pixels.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
            if (pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
        end
    end

    // FIFO storage write.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= pixel_in;
    end

endmodule
